// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Loader FSM states, word geometry and the load-length legality rule.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH     = 256;
    localparam int unsigned IMEM_ADDR_W    = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCsum,
        StDone,
        StErr
    } load_state_e;

    // A load must write at least one word and must not run past the end of RAM.
    function automatic logic len_legal(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_dp_ram.sv
// Instruction RAM: one synchronous write port for the loader and one
// asynchronous read port for the fetch stage. Contents are not reset.
module imem_dp_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read of the word being written returns the old value until the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream into instruction words, writes them to RAM,
// verifies a trailing 32-bit sum and releases the core only on success.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [31:0]       fetch_addr,
    output logic [WORD_W-1:0] fetch_instr,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    load_state_e       state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [23:0]       shift_q, shift_d;
    logic [23:0]       shift_ins;
    logic [WORD_W-1:0] full_word;
    logic              byte_fire;
    logic              last_byte;
    logic              ram_we;
    logic              unused_fetch_bits;

    assign byte_fire = s_valid & s_ready;
    assign last_byte = (byte_idx_q == 2'd3);
    // The fourth byte completes the word straight from the input, no extra cycle.
    assign full_word = {s_data, shift_q};

    always_comb begin
        shift_ins = shift_q;
        case (byte_idx_q)
            2'd0:    shift_ins[7:0]   = s_data;
            2'd1:    shift_ins[15:8]  = s_data;
            2'd2:    shift_ins[23:16] = s_data;
            default: shift_ins        = shift_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            byte_idx_q     <= '0;
            word_ptr_q     <= '0;
            words_loaded_q <= '0;
            len_q          <= '0;
            sum_q          <= '0;
            shift_q        <= '0;
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            word_ptr_q     <= word_ptr_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
            sum_q          <= sum_d;
            shift_q        <= shift_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        word_ptr_d     = word_ptr_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        sum_d          = sum_q;
        shift_d        = shift_q;
        ram_we         = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load_start) begin
                    if (len_legal(32'(load_len), DEPTH)) begin
                        state_d        = StRecv;
                        byte_idx_d     = '0;
                        word_ptr_d     = '0;
                        words_loaded_d = '0;
                        sum_d          = '0;
                        len_d          = load_len;
                    end else begin
                        // Rejected length keeps the previous load's word count visible.
                        state_d = StErr;
                    end
                end
            end
            StRecv: begin
                if (byte_fire) begin
                    if (last_byte) begin
                        ram_we         = 1'b1;
                        byte_idx_d     = '0;
                        word_ptr_d     = word_ptr_q + PTR_ONE;
                        words_loaded_d = words_loaded_q + CNT_ONE;
                        sum_d          = sum_q + full_word;
                        if ((words_loaded_q + CNT_ONE) == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        shift_d    = shift_ins;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StCsum: begin
                if (byte_fire) begin
                    if (last_byte) begin
                        byte_idx_d = '0;
                        state_d    = (full_word == sum_q) ? StDone : StErr;
                    end else begin
                        shift_d    = shift_ins;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == StRecv) || (state_q == StCsum);
        core_hold = (state_q != StDone);
        load_done = (state_q == StDone);
        load_err  = (state_q == StErr);
    end

    assign words_loaded = words_loaded_q;

    // Fetch addresses wrap: only the word-index bits select a RAM entry.
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    imem_dp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_ptr_q),
        .wdata (full_word),
        .raddr (fetch_addr[ADDR_W+1:2]),
        .rdata (fetch_instr)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed loads, a table of load
// scenarios and randomized streams checked against a word-level RAM model.
module tb_imem_boot_loader;
    import imem_pkg::*;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len   = '0;
    logic              s_valid    = 1'b0;
    logic [7:0]        s_data     = '0;
    logic [31:0]       fetch_addr = '0;
    logic              s_ready;
    logic              core_hold;
    logic              load_done;
    logic              load_err;
    logic [31:0]       fetch_instr;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_len     (load_len),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Word-level model: what RAM must hold and how many words the last load wrote.
    logic [31:0] mem_model  [DEPTH];
    bit          mem_known  [DEPTH];
    logic [31:0] stim_words [DEPTH];
    int          model_wl = 0;

    typedef struct {
        int len;
        int csum_mode;
        int gap;
        bit exp_done;
        bit exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int w = 0; w < int'(DEPTH); w++) begin
            if (mem_known[w]) begin
                fetch_addr = ($urandom & 32'hFFFF_FC03) | (32'(w) << 2);
                #1;
                check($sformatf("%s[%0d]", tag, w), fetch_instr, mem_model[w]);
            end
        end
    endtask

    task automatic fill_random();
        for (int w = 0; w < int'(DEPTH); w++) stim_words[w] = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output logic [31:0] pre_instr,
                             output logic pre_hold, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = b;
            end
            #1;
            if (s_valid && s_ready) ok = 1'b1;
        end
        pre_instr = fetch_instr;
        pre_hold  = core_hold;
        if (ok) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    // csum_mode: 0 = correct sum, 1 = sum with one bit flipped, 2 = csum_val as given.
    task automatic run_load(input int len, input int csum_mode, input logic [31:0] csum_val,
                            input int gap, input int abort_bytes);
        logic [31:0] sum;
        logic [31:0] csum;
        logic [31:0] pre;
        logic        pre_hold;
        bit          ok;
        bit          exp_done;
        int          nbytes;
        nbytes = 0;
        sum    = '0;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = (ADDR_W + 1)'(len);
        @(negedge clk);
        load_start = 1'b0;
        if (len < 1 || len > int'(DEPTH)) begin
            check("badlen_err", 32'(load_err), 32'd1);
            check("badlen_ready", 32'(s_ready), 32'd0);
            check("badlen_done", 32'(load_done), 32'd0);
            check("badlen_wl", 32'(words_loaded), 32'(model_wl));
            return;
        end
        model_wl = 0;
        check("start_ready", 32'(s_ready), 32'd1);
        check("start_wl", 32'(words_loaded), 32'd0);
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (abort_bytes > 0 && nbytes == abort_bytes) return;
                if (k == 3) fetch_addr = 32'(w) << 2;
                send_byte(stim_words[w][8*k +: 8], gap, pre, pre_hold, ok);
                nbytes++;
                check("byte_timeout", 32'(ok), 32'd1);
                if (!ok) return;
                if (k == 3) begin
                    if (mem_known[w]) check("read_old_during_write", pre, mem_model[w]);
                    mem_model[w] = stim_words[w];
                    mem_known[w] = 1'b1;
                    model_wl++;
                    sum += stim_words[w];
                    if (w == len - 1 || (w % 37) == 0) begin
                        check("wl_progress", 32'(words_loaded), 32'(model_wl));
                    end
                end
            end
        end
        case (csum_mode)
            0:       csum = sum;
            1:       csum = sum ^ (32'd1 << $urandom_range(31));
            default: csum = csum_val;
        endcase
        for (int k = 0; k < 4; k++) begin
            send_byte(csum[8*k +: 8], gap, pre, pre_hold, ok);
            check("csum_timeout", 32'(ok), 32'd1);
            if (!ok) return;
        end
        check("hold_at_last_handshake", 32'(pre_hold), 32'd1);
        exp_done = (csum == sum);
        check("done", 32'(load_done), 32'(exp_done));
        check("err", 32'(load_err), 32'(!exp_done));
        check("core_hold", 32'(core_hold), 32'(!exp_done));
        check("ready_after", 32'(s_ready), 32'd0);
        check("wl_final", 32'(words_loaded), 32'(model_wl));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{len: 1,   csum_mode: 0, gap: 0,  exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{len: 3,   csum_mode: 0, gap: 30, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{len: 2,   csum_mode: 1, gap: 0,  exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{len: 0,   csum_mode: 0, gap: 0,  exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{len: 7,   csum_mode: 0, gap: 70, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{len: 511, csum_mode: 0, gap: 0,  exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{len: 5,   csum_mode: 1, gap: 50, exp_done: 1'b0, exp_err: 1'b1};
        vecs[7] = '{len: 16,  csum_mode: 0, gap: 20, exp_done: 1'b1, exp_err: 1'b0};

        // Reset state, visible without any clock edge.
        #1;
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_wl", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // A byte offered while idle must not be taken.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("idle_no_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;

        // Two-instruction program with its correct sum.
        stim_words[0] = 32'h0000_0013;
        stim_words[1] = 32'h0010_0093;
        run_load(2, 2, 32'h0010_00A6, 0, 0);
        check("prog_done", 32'(load_done), 32'd1);
        check("prog_hold", 32'(core_hold), 32'd0);
        fetch_addr = 32'h4;
        #1;
        check("fetch_4", fetch_instr, 32'h0010_0093);
        fetch_addr = 32'h0;
        #1;
        check("fetch_0", fetch_instr, 32'h0000_0013);

        // Same program, zero checksum.
        run_load(2, 2, 32'h0, 0, 0);
        check("zero_csum_err", 32'(load_err), 32'd1);
        check("zero_csum_wl", 32'(words_loaded), 32'd2);

        // Illegal lengths; stream offered afterwards must stay unconsumed.
        run_load(0, 0, 32'h0, 0, 0);
        run_load(int'(DEPTH) + 1, 0, 32'h0, 0, 0);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (4) @(negedge clk);
        check("err_no_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        check_ram("ram_after_badlen");

        for (int i = 0; i < 8; i++) begin
            fill_random();
            run_load(vecs[i].len, vecs[i].csum_mode, 32'h0, vecs[i].gap, 0);
            check($sformatf("tbl%0d_done", i), 32'(load_done), 32'(vecs[i].exp_done));
            check($sformatf("tbl%0d_err", i), 32'(load_err), 32'(vecs[i].exp_err));
        end
        check_ram("ram_after_table");

        // Full RAM with a 50% valid duty cycle; address 0x400 wraps to word 0.
        fill_random();
        run_load(int'(DEPTH), 0, 32'h0, 50, 0);
        check("full_done", 32'(load_done), 32'd1);
        check("full_wl", 32'(words_loaded), 32'(DEPTH));
        check_ram("ram_full");
        fetch_addr = 32'h400;
        #1;
        check("fetch_wrap", fetch_instr, mem_model[0]);

        // Reset after five bytes of a four-word load.
        fill_random();
        run_load(4, 0, 32'h0, 0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hold", 32'(core_hold), 32'd1);
        check("midrst_ready", 32'(s_ready), 32'd0);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_wl", 32'(words_loaded), 32'd0);
        model_wl = 0;
        @(negedge clk);
        rst_n = 1'b1;
        fetch_addr = 32'h0;
        #1;
        check("midrst_word0_kept", fetch_instr, stim_words[0]);
        fill_random();
        run_load(4, 0, 32'h0, 10, 0);
        check("reload_done", 32'(load_done), 32'd1);
        check_ram("ram_after_reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
